// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the imem read port, tags returning
// instructions with their byte PC and buffers them in a FIFO ahead of decode.
module fetch_queue #(
  parameter int MEM_LATENCY = 2,
  parameter int DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic [14:0] imem_raddr,
  input  logic [15:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_pc,
  output logic [15:0] out_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]            pc_q, pc_d;
  logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [15:0]            tag_pc_q [MEM_LATENCY];
  logic [15:0]            fifo_pc_q [DEPTH];
  logic [15:0]            fifo_instr_q [DEPTH];
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [15:0]            hold_pc_q, hold_instr_q;

  logic [CW:0] inflight;
  logic [CW:0] occupancy;
  logic        issue, push, pop;

  assign imem_raddr = pc_q[15:1];
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? fifo_pc_q[rd_ptr_q]    : hold_pc_q;
  assign out_instr  = out_valid ? fifo_instr_q[rd_ptr_q] : hold_instr_q;

  // Credits: registered FIFO occupancy plus every fetch still in the memory pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + (CW+1)'(tag_vld_q[i]);
    end
    occupancy = {1'b0, count_q} + inflight;
    issue     = !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    push      = tag_vld_q[MEM_LATENCY-1];
    pop       = out_valid && out_ready;
  end

  always_comb begin
    pc_d      = pc_q;
    tag_vld_d = tag_vld_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (redirect_valid) begin
      // Wrong-path work is dropped wholesale, including this cycle's pop and return.
      pc_d      = redirect_pc & 16'hFFFE;
      tag_vld_d = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (issue) pc_d = pc_q + 16'd2;
      tag_vld_d[0] = issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_vld_d[i] = tag_vld_q[i-1];
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      tag_vld_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      pc_q      <= pc_d;
      tag_vld_q <= tag_vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      if (out_valid) begin
        hold_pc_q    <= fifo_pc_q[rd_ptr_q];
        hold_instr_q <= fifo_instr_q[rd_ptr_q];
      end
    end
  end

  // Tag PCs and FIFO payload need no reset; only the valids and pointers qualify them.
  always_ff @(posedge clk) begin
    tag_pc_q[0] <= pc_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_pc_q[i] <= tag_pc_q[i-1];
    end
    if (!reset && !redirect_valid && push) begin
      fifo_pc_q[wr_ptr_q]    <= tag_pc_q[MEM_LATENCY-1];
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: latency memory model, in-order PC stream model checked every
// cycle, and directed scenarios with hand-computed cycle-exact expectations.
module tb_fetch_queue;
  localparam int L = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [14:0] imem_raddr;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [15:0] out_instr;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  fetch_queue #(.MEM_LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // Memory: mem[w] = w, answering L cycles after the address is presented.
  logic [14:0] addr_d [L];
  always @(posedge clk) begin
    addr_d[0] <= imem_raddr;
    for (int i = 1; i < L; i++) addr_d[i] <= addr_d[i-1];
  end
  assign imem_rdata = {1'b0, addr_d[L-1]};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: next PC decode must see, value held while empty, and forced-empty cycles.
  logic [15:0] exp_next = '0;
  logic [15:0] exp_hold = '0;
  logic        exp_empty = 1'b1;
  always @(posedge clk) begin
    exp_empty <= reset || redirect_valid;
    if (reset) begin
      exp_next <= '0;
      exp_hold <= '0;
    end else begin
      if (out_valid) exp_hold <= exp_next;
      if (redirect_valid)              exp_next <= redirect_pc & 16'hFFFE;
      else if (out_valid && out_ready) exp_next <= exp_next + 16'd2;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (out_valid) begin
        chk("model_pc", out_pc, exp_next);
        chk("model_instr", out_instr, {1'b0, exp_next[15:1]});
      end else begin
        chk("hold_pc", out_pc, exp_hold);
        chk("hold_instr", out_instr, {1'b0, exp_hold[15:1]});
      end
      if (exp_empty) chk("flush_empty", {15'd0, out_valid}, 16'd0);
      vectors++;
      if (dut.count_q > D) begin
        miscompares++;
        $display("FAIL overflow: count %0d exceeds %0d", dut.count_q, D);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Redirect in cycle t: empty through t+3, first new-path instruction at t+4.
  task automatic redirect_to(input logic [15:0] pc, input logic [15:0] exp_first);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("redir_gap", {15'd0, out_valid}, 16'd0);
      tick();
    end
    chk("redir_valid", {15'd0, out_valid}, 16'd1);
    chk("redir_pc", out_pc, exp_first);
  endtask

  logic [31:0] ready_pat = 32'b1011_0010_1110_0101_0011_1100_1001_0111;

  initial begin
    // Test 1: stream from reset.
    out_ready = 1'b1;
    do_reset(2);
    chk_en = 1'b1;
    chk("t1_reset_pc", out_pc, 16'h0000);
    chk("t1_reset_instr", out_instr, 16'h0000);
    chk("t1_raddr0", {1'b0, imem_raddr}, 16'h0000);
    for (int c = 0; c < 3; c++) begin
      chk("t1_empty", {15'd0, out_valid}, 16'd0);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk("t1_valid", {15'd0, out_valid}, 16'd1);
      chk("t1_pc", out_pc, 16'(2 * k));
      chk("t1_instr", out_instr, 16'(k));
      tick();
    end

    // Test 2: decode stalled from reset fills exactly DEPTH entries.
    out_ready = 1'b0;
    do_reset(2);
    repeat (8) tick();
    chk("t2_valid", {15'd0, out_valid}, 16'd1);
    chk("t2_head", out_pc, 16'h0000);
    chk("t2_raddr", {1'b0, imem_raddr}, 16'h0004);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t2_valid_run", {15'd0, out_valid}, 16'd1);
      chk("t2_pc", out_pc, 16'(2 * k));
      tick();
    end

    // Test 3: redirect in cycle 10 while streaming.
    do_reset(2);
    repeat (10) tick();
    redirect_to(16'h0040, 16'h0040);
    repeat (3) tick();

    // Test 4: bit 0 of the redirect target is ignored.
    redirect_to(16'h0041, 16'h0040);
    tick();
    chk("t4_next", out_pc, 16'h0042);

    // Test 5: wrap through 0xFFFE.
    redirect_to(16'hFFFC, 16'hFFFC);
    chk("t5_instr0", out_instr, 16'h7FFE);
    tick();
    chk("t5_pc1", out_pc, 16'hFFFE);
    chk("t5_instr1", out_instr, 16'h7FFF);
    tick();
    chk("t5_pc2", out_pc, 16'h0000);
    tick();
    chk("t5_pc3", out_pc, 16'h0002);
    chk("t5_instr3", out_instr, 16'h0001);

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect_to(16'h0200, 16'h0200);

    // Irregular decode stalls; the stream model checks order and hold values.
    for (int k = 0; k < 32; k++) begin
      out_ready = ready_pat[k];
      tick();
    end
    out_ready = 1'b1;
    repeat (6) tick();

    // Test 6: reset mid-stream with entries buffered, redirect in the same cycle ignored.
    out_ready = 1'b0;
    repeat (3) tick();
    chk("t6_buffered", {15'd0, out_valid}, 16'd1);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    tick();
    reset = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    chk("t6_empty", {15'd0, out_valid}, 16'd0);
    chk("t6_pc_cleared", out_pc, 16'h0000);
    chk("t6_raddr", {1'b0, imem_raddr}, 16'h0000);
    repeat (3) tick();
    chk("t6_valid", {15'd0, out_valid}, 16'd1);
    chk("t6_pc", out_pc, 16'h0000);
    tick();
    chk("t6_pc_next", out_pc, 16'h0002);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
